// File: rtl/debug_pkg.sv
// Shared types and default sizes for the debug run-control block.
package debug_pkg;

  localparam int PC_W_DEF   = 9;
  localparam int NUM_BP_DEF = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_HALTED   = 2'd1,
    ST_STEPPING = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_RUN    = 2'b00,
    OP_HALT   = 2'b01,
    OP_STEP   = 2'b10,
    OP_SET_BP = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_HALT = 2'b01,
    CAUSE_BP   = 2'b10,
    CAUSE_STEP = 2'b11
  } halt_cause_e;

endpackage

// File: rtl/debug_bp_match.sv
// Combinational compare of the fetch PC against all breakpoint slots.
module debug_bp_match #(
  parameter int PC_W   = 9,
  parameter int NUM_BP = 4,
  parameter int IDX_W  = $clog2(NUM_BP)
) (
  input  logic [PC_W-1:0]              pc,
  input  logic [NUM_BP-1:0][PC_W-1:0]  slot_addr,
  input  logic [NUM_BP-1:0]            slot_en,
  output logic                         hit,
  output logic [IDX_W-1:0]             idx
);

  // Scan high to low so the lowest matching slot is the one left in idx.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (slot_en[i] && (slot_addr[i] == pc)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/debug_run_ctrl.sv
// Debug run control: run/halt/single-step FSM with PC breakpoints.
module debug_run_ctrl
  import debug_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int NUM_BP = NUM_BP_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dbg_en,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [PC_W-1:0]            cmd_arg,
  input  logic [$clog2(NUM_BP)-1:0]  cmd_bp_idx,
  input  logic                       cmd_bp_en,
  input  logic [PC_W-1:0]            pc_fetch,
  input  logic                       pc_valid,
  output logic                       stall_out,
  output logic                       halted,
  output logic [1:0]                 halt_cause,
  output logic [$clog2(NUM_BP)-1:0]  bp_hit_idx,
  output logic [PC_W-1:0]            steps_left
);

  localparam int IDX_W = $clog2(NUM_BP);

  state_e                      state;
  halt_cause_e                 cause;
  logic                        bp_mask;
  logic [NUM_BP-1:0][PC_W-1:0] slot_addr;
  logic [NUM_BP-1:0]           slot_en;

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             cmd_fire;
  logic             bp_take;

  debug_bp_match #(
    .PC_W   (PC_W),
    .NUM_BP (NUM_BP),
    .IDX_W  (IDX_W)
  ) u_match (
    .pc        (pc_fetch),
    .slot_addr (slot_addr),
    .slot_en   (slot_en),
    .hit       (hit),
    .idx       (hit_idx)
  );

  assign cmd_ready  = dbg_en;
  assign cmd_fire   = cmd_valid & dbg_en;
  // A breakpoint only fires in RUN, and not on the PC we just resumed from.
  assign bp_take    = dbg_en && (state == ST_RUN) && pc_valid && hit && !bp_mask;
  assign stall_out  = dbg_en && ((state == ST_HALTED) || bp_take);
  assign halted     = (state == ST_HALTED);
  assign halt_cause = cause;

  // Run-control FSM; later assignments win, so a breakpoint outranks commands.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RUN;
      cause      <= CAUSE_NONE;
      bp_mask    <= 1'b0;
      bp_hit_idx <= '0;
      steps_left <= '0;
      slot_addr  <= '0;
      slot_en    <= '0;
    end else if (!dbg_en) begin
      state   <= ST_RUN;
      cause   <= CAUSE_NONE;
      bp_mask <= 1'b0;
    end else begin
      // First fetched instruction after resume clears the skip-once mask.
      if ((state == ST_RUN) && bp_mask && pc_valid)
        bp_mask <= 1'b0;

      if ((state == ST_STEPPING) && pc_valid && (steps_left != '0)) begin
        steps_left <= steps_left - PC_W'(1);
        if (steps_left == PC_W'(1)) begin
          state <= ST_HALTED;
          cause <= CAUSE_STEP;
        end
      end

      if (cmd_fire) begin
        case (cmd_op_e'(cmd_op))
          OP_RUN: begin
            cause <= CAUSE_NONE;
            if (state != ST_RUN) begin
              state   <= ST_RUN;
              bp_mask <= 1'b1;
            end
          end
          OP_HALT: begin
            state <= ST_HALTED;
            cause <= CAUSE_HALT;
          end
          OP_STEP: begin
            if (state == ST_HALTED) begin
              steps_left <= (cmd_arg == '0) ? PC_W'(1) : cmd_arg;
              state      <= ST_STEPPING;
            end
          end
          OP_SET_BP: begin
            slot_addr[cmd_bp_idx] <= cmd_arg;
            slot_en[cmd_bp_idx]   <= cmd_bp_en;
          end
          default: ;
        endcase
      end

      if (bp_take) begin
        state      <= ST_HALTED;
        cause      <= CAUSE_BP;
        bp_hit_idx <= hit_idx;
      end
    end
  end

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Table-driven bench for debug_run_ctrl with a queue scoreboard for registered outputs.
module tb_debug_run_ctrl;

  localparam int PC_W   = 9;
  localparam int NUM_BP = 4;
  localparam int IDX_W  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              dbg_en;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [PC_W-1:0]   cmd_arg;
  logic [IDX_W-1:0]  cmd_bp_idx;
  logic              cmd_bp_en;
  logic [PC_W-1:0]   pc_fetch;
  logic              pc_valid;
  logic              stall_out;
  logic              halted;
  logic [1:0]        halt_cause;
  logic [IDX_W-1:0]  bp_hit_idx;
  logic [PC_W-1:0]   steps_left;

  debug_run_ctrl #(.PC_W(PC_W), .NUM_BP(NUM_BP)) dut (
    .clk        (clk),
    .reset      (reset),
    .dbg_en     (dbg_en),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .cmd_bp_idx (cmd_bp_idx),
    .cmd_bp_en  (cmd_bp_en),
    .pc_fetch   (pc_fetch),
    .pc_valid   (pc_valid),
    .stall_out  (stall_out),
    .halted     (halted),
    .halt_cause (halt_cause),
    .bp_hit_idx (bp_hit_idx),
    .steps_left (steps_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rst, en, cv, op, arg, bi, be, pc, pv;  // inputs for one cycle
    int x_stall, x_ready;                      // combinational, before the edge
    int x_halted, x_cause, x_idx, x_steps;     // registered, after the edge
  } vec_t;

  typedef struct {
    int n;
    int halted, cause, idx, steps;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  localparam int R = 0, H = 1, S = 2, B = 3;  // command opcodes

  function automatic vec_t mk(int rst, int en, int cv, int op, int arg, int bi, int be,
                              int pc, int pv, int xs, int xr, int xh, int xc, int xi, int xst);
    vec_t v;
    v.rst = rst; v.en = en; v.cv = cv; v.op = op; v.arg = arg; v.bi = bi; v.be = be;
    v.pc = pc; v.pv = pv; v.x_stall = xs; v.x_ready = xr;
    v.x_halted = xh; v.x_cause = xc; v.x_idx = xi; v.x_steps = xst;
    return v;
  endfunction

  task automatic chk(input int n, input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL vec%0d %s: got %0d expected %0d", n, name, act, exp);
    end
  endtask

  // Drive one vector, check comb outputs, push registered expectations, pop after the edge.
  task automatic apply(input int n, input vec_t v);
    exp_t e, g;
    @(negedge clk);
    reset      = v.rst[0];
    dbg_en     = v.en[0];
    cmd_valid  = v.cv[0];
    cmd_op     = v.op[1:0];
    cmd_arg    = v.arg[PC_W-1:0];
    cmd_bp_idx = v.bi[IDX_W-1:0];
    cmd_bp_en  = v.be[0];
    pc_fetch   = v.pc[PC_W-1:0];
    pc_valid   = v.pv[0];
    #1;
    chk(n, "stall_out", int'(stall_out), v.x_stall);
    chk(n, "cmd_ready", int'(cmd_ready), v.x_ready);
    e.n = n; e.halted = v.x_halted; e.cause = v.x_cause; e.idx = v.x_idx; e.steps = v.x_steps;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk(g.n, "halted",     int'(halted),     g.halted);
    chk(g.n, "halt_cause", int'(halt_cause), g.cause);
    chk(g.n, "bp_hit_idx", int'(bp_hit_idx), g.idx);
    chk(g.n, "steps_left", int'(steps_left), g.steps);
  endtask

  initial begin
    reset = 1'b1; dbg_en = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0;
    cmd_bp_idx = '0; cmd_bp_en = 1'b0; pc_fetch = '0; pc_valid = 1'b0;
    repeat (2) @(posedge clk);

    //           rst en cv op arg    bi be pc     pv  st rd  hl ca ix steps
    tbl.push_back(mk(1, 1, 0, 0, 0,     0, 0, 0,     0,  0, 1,  0, 0, 0, 0));  // 0 reset state
    tbl.push_back(mk(0, 1, 1, B, 'h40,  2, 1, 0,     0,  0, 1,  0, 0, 0, 0));  // 1 slot2=0x040
    tbl.push_back(mk(0, 1, 0, 0, 0,     0, 0, 'h38,  1,  0, 1,  0, 0, 0, 0));  // 2
    tbl.push_back(mk(0, 1, 0, 0, 0,     0, 0, 'h3C,  1,  0, 1,  0, 0, 0, 0));  // 3
    tbl.push_back(mk(0, 1, 0, 0, 0,     0, 0, 'h40,  1,  1, 1,  1, 2, 2, 0));  // 4 bp hit
    tbl.push_back(mk(0, 1, 0, 0, 0,     0, 0, 'h40,  0,  1, 1,  1, 2, 2, 0));  // 5 held
    tbl.push_back(mk(0, 1, 1, R, 0,     0, 0, 'h40,  0,  1, 1,  0, 0, 2, 0));  // 6 resume
    tbl.push_back(mk(0, 1, 0, 0, 0,     0, 0, 'h40,  1,  0, 1,  0, 0, 2, 0));  // 7 skip once
    tbl.push_back(mk(0, 1, 0, 0, 0,     0, 0, 'h44,  1,  0, 1,  0, 0, 2, 0));  // 8
    tbl.push_back(mk(0, 1, 0, 0, 0,     0, 0, 'h40,  1,  1, 1,  1, 2, 2, 0));  // 9 re-halt
    tbl.push_back(mk(0, 1, 1, S, 3,     0, 0, 'h40,  0,  1, 1,  0, 2, 2, 3));  // 10 STEP 3
    tbl.push_back(mk(0, 1, 0, 0, 0,     0, 0, 'h40,  1,  0, 1,  0, 2, 2, 2));  // 11 bp ignored
    tbl.push_back(mk(0, 1, 0, 0, 0,     0, 0, 'h44,  0,  0, 1,  0, 2, 2, 2));  // 12 no fetch
    tbl.push_back(mk(0, 1, 0, 0, 0,     0, 0, 'h44,  1,  0, 1,  0, 2, 2, 1));  // 13
    tbl.push_back(mk(0, 1, 0, 0, 0,     0, 0, 'h48,  1,  0, 1,  1, 3, 2, 0));  // 14 step done
    tbl.push_back(mk(0, 1, 1, S, 0,     0, 0, 'h4C,  0,  1, 1,  0, 3, 2, 1));  // 15 STEP 0 -> 1
    tbl.push_back(mk(0, 1, 0, 0, 0,     0, 0, 'h4C,  1,  0, 1,  1, 3, 2, 0));  // 16
    tbl.push_back(mk(0, 1, 0, 0, 0,     0, 0, 'h50,  1,  1, 1,  1, 3, 2, 0));  // 17 only one
    tbl.push_back(mk(0, 1, 1, R, 0,     0, 0, 'h50,  0,  1, 1,  0, 0, 2, 0));  // 18
    tbl.push_back(mk(0, 1, 0, 0, 0,     0, 0, 'h50,  1,  0, 1,  0, 0, 2, 0));  // 19 mask clear
    tbl.push_back(mk(0, 1, 1, H, 0,     0, 0, 'h40,  1,  1, 1,  1, 2, 2, 0));  // 20 HALT+bp
    tbl.push_back(mk(0, 1, 1, B, 'h60,  3, 1, 0,     0,  1, 1,  1, 2, 2, 0));  // 21 slot3
    tbl.push_back(mk(0, 1, 1, B, 'h60,  1, 1, 0,     0,  1, 1,  1, 2, 2, 0));  // 22 slot1
    tbl.push_back(mk(0, 1, 1, H, 0,     0, 0, 0,     0,  1, 1,  1, 1, 2, 0));  // 23 HALT in HALTED
    tbl.push_back(mk(0, 1, 1, R, 0,     0, 0, 0,     0,  1, 1,  0, 0, 2, 0));  // 24
    tbl.push_back(mk(0, 1, 0, 0, 0,     0, 0, 0,     1,  0, 1,  0, 0, 2, 0));  // 25 slot0 off
    tbl.push_back(mk(0, 1, 0, 0, 0,     0, 0, 'h60,  1,  1, 1,  1, 2, 1, 0));  // 26 lowest=1
    tbl.push_back(mk(0, 1, 1, R, 0,     0, 0, 0,     0,  1, 1,  0, 0, 1, 0));  // 27
    tbl.push_back(mk(0, 1, 0, 0, 0,     0, 0, 'h70,  1,  0, 1,  0, 0, 1, 0));  // 28
    tbl.push_back(mk(0, 1, 1, B, 'h70,  0, 1, 'h70,  1,  0, 1,  0, 0, 1, 0));  // 29 old contents
    tbl.push_back(mk(0, 1, 0, 0, 0,     0, 0, 'h70,  1,  1, 1,  1, 2, 0, 0));  // 30 new contents
    tbl.push_back(mk(0, 1, 1, B, 'h70,  0, 0, 0,     0,  1, 1,  1, 2, 0, 0));  // 31 disable
    tbl.push_back(mk(0, 1, 1, R, 0,     0, 0, 0,     0,  1, 1,  0, 0, 0, 0));  // 32
    tbl.push_back(mk(0, 1, 0, 0, 0,     0, 0, 'h80,  1,  0, 1,  0, 0, 0, 0));  // 33
    tbl.push_back(mk(0, 1, 0, 0, 0,     0, 0, 'h70,  1,  0, 1,  0, 0, 0, 0));  // 34 disabled
    tbl.push_back(mk(0, 1, 1, H, 0,     0, 0, 0,     0,  0, 1,  1, 1, 0, 0));  // 35 HALT
    tbl.push_back(mk(0, 0, 0, 0, 0,     0, 0, 0,     0,  0, 0,  0, 0, 0, 0));  // 36 dbg_en off
    tbl.push_back(mk(0, 0, 0, 0, 0,     0, 0, 'h40,  1,  0, 0,  0, 0, 0, 0));  // 37 no bp
    tbl.push_back(mk(0, 0, 1, H, 0,     0, 0, 0,     0,  0, 0,  0, 0, 0, 0));  // 38 not taken
    tbl.push_back(mk(0, 1, 0, 0, 0,     0, 0, 0,     0,  0, 1,  0, 0, 0, 0));  // 39
    tbl.push_back(mk(0, 1, 1, S, 5,     0, 0, 0,     0,  0, 1,  0, 0, 0, 0));  // 40 STEP in RUN
    tbl.push_back(mk(0, 1, 1, H, 0,     0, 0, 0,     0,  0, 1,  1, 1, 0, 0));  // 41
    tbl.push_back(mk(0, 1, 1, S, 5,     0, 0, 0,     0,  1, 1,  0, 1, 0, 5));  // 42 STEP 5
    tbl.push_back(mk(0, 1, 1, S, 9,     0, 0, 'h90,  1,  0, 1,  0, 1, 0, 4));  // 43 STEP ignored
    tbl.push_back(mk(1, 1, 1, H, 0,     0, 0, 'h40,  1,  0, 1,  0, 0, 0, 0));  // 44 reset wins
    tbl.push_back(mk(0, 1, 0, 0, 0,     0, 0, 'h40,  1,  0, 1,  0, 0, 0, 0));  // 45 slots cleared

    foreach (tbl[i]) apply(i, tbl[i]);

    // Hand sequence: fresh breakpoint at 0x040 after reset, then a short step burst.
    apply(100, mk(0, 1, 1, B, 'h40, 0, 1, 0,    0, 0, 1, 0, 0, 0, 0));
    apply(101, mk(0, 1, 0, 0, 0,    0, 0, 'h40, 1, 1, 1, 1, 2, 0, 0));
    apply(102, mk(0, 1, 1, S, 2,    0, 0, 'h40, 0, 1, 1, 0, 2, 0, 2));
    apply(103, mk(0, 1, 0, 0, 0,    0, 0, 'h40, 1, 0, 1, 0, 2, 0, 1));
    apply(104, mk(0, 1, 0, 0, 0,    0, 0, 'h44, 1, 0, 1, 1, 3, 0, 0));

    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
